bram_rd_seq: RTL and testbench

BRAM_RD_SEQ -- requirements
Module: bram_rd_seq

---
 rtl/bram_rd_seq_pkg.sv | 14 +
 rtl/bram_rd_seq_vld_pipe.sv | 34 +++
 rtl/bram_rd_seq.sv | 126 ++++++++++++
 tb/tb_bram_rd_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_rd_seq_pkg.sv
// Shared types and constants for the BRAM port-B read sequencer.
package bram_rd_seq_pkg;

  // Width of the byte-rotation select (one of four byte lanes).
  localparam int SEL_W = 2;

  // Sequencer states: waiting for a request, issuing reads, draining returns.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/bram_rd_seq_vld_pipe.sv
// Two-stage valid delay line: stage 1 lines up with BRAM read data,
// stage 2 lines up with the rotation stage's registered output.
module vld_pipe (
  input  logic clk,
  input  logic rst_n,
  input  logic en_in,
  output logic sm_en,
  output logic out_valid
);

  logic stage1_q, stage1_d;
  logic stage2_q, stage2_d;

  // Next values simply shift the read enable down the line.
  always_comb begin
    stage1_d = en_in;
    stage2_d = stage1_q;
  end

  // Delay registers; clearing them drops any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_q <= 1'b0;
      stage2_q <= 1'b0;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign sm_en     = stage1_q;
  assign out_valid = stage2_q;

endmodule

// File: rtl/bram_rd_seq.sv
// BRAM port-B read sequencer: issues LEN word reads from a byte start
// address, tracks returning beats and pulses DONE on the last one.
module bram_rd_seq
  import bram_rd_seq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 12
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [ADDR_W+1:0] START_ADDR,
  input  logic [LEN_W-1:0]  LEN,
  input  logic              STALL,
  output logic              EN_B,
  output logic [ADDR_W-1:0] ADDR_B,
  output logic              SM_EN,
  output logic [SEL_W-1:0]  Sel,
  output logic              OUT_VALID,
  output logic              BUSY,
  output logic              DONE
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  word_addr_q, word_addr_d;
  logic [LEN_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]   ret_cnt_q, ret_cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               zero_done_q, zero_done_d;

  logic               issue;
  logic               last_beat;

  // A read goes out whenever we are issuing and downstream is not pushing back.
  assign issue     = (state_q == ST_ISSUE) && !STALL;
  // The beat that brings the return count up to the latched length ends the transfer.
  assign last_beat = OUT_VALID && (state_q != ST_IDLE) &&
                     (ret_cnt_q == (len_q - LEN_W'(1)));

  // Next-state and datapath updates for the request, issue and return sides.
  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    len_d       = len_q;
    sel_d       = sel_q;
    zero_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (LEN != '0) begin
            word_addr_d = START_ADDR[ADDR_W+1:2];
            issue_cnt_d = LEN;
            len_d       = LEN;
            ret_cnt_d   = '0;
            sel_d       = START_ADDR[1:0];
            state_d     = ST_ISSUE;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          word_addr_d = word_addr_q + ADDR_W'(1);
          issue_cnt_d = issue_cnt_q - LEN_W'(1);
          if (issue_cnt_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (last_beat) begin
          state_d = ST_IDLE;
          sel_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (OUT_VALID && (state_q != ST_IDLE)) begin
      ret_cnt_d = ret_cnt_q + LEN_W'(1);
    end
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      word_addr_q <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      len_q       <= '0;
      sel_q       <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      len_q       <= len_d;
      sel_q       <= sel_d;
      zero_done_q <= zero_done_d;
    end
  end

  vld_pipe u_vld_pipe (
    .clk       (CLK),
    .rst_n     (RST_N),
    .en_in     (issue),
    .sm_en     (SM_EN),
    .out_valid (OUT_VALID)
  );

  assign EN_B   = issue;
  assign ADDR_B = word_addr_q;
  assign Sel    = sel_q;
  assign BUSY   = (state_q != ST_IDLE);
  assign DONE   = zero_done_q | last_beat;

endmodule

// File: tb/tb_bram_rd_seq.sv
// Randomised bench for bram_rd_seq with a transfer-level reference model.
module tb_bram_rd_seq;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 12;
  localparam int AMOD   = 1 << ADDR_W;
  localparam int MAXC   = 256;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              START = 1'b0;
  logic [ADDR_W+1:0] START_ADDR = '0;
  logic [LEN_W-1:0]  LEN = '0;
  logic              STALL = 1'b0;
  logic              EN_B;
  logic [ADDR_W-1:0] ADDR_B;
  logic              SM_EN;
  logic [1:0]        Sel;
  logic              OUT_VALID;
  logic              BUSY;
  logic              DONE;

  int checks = 0;
  int errors = 0;

  // Observations of one transfer.
  bit en_h[MAXC];
  bit sm_h[MAXC];
  bit vld_h[MAXC];
  int addr_obs[$];
  int ncyc, done_cnt, done_cyc, vld_cnt, first_vld, last_vld;
  int first_en, last_en, sel_bad, busy_after, busy_cnt;
  bit timeout;

  always #5 CLK = ~CLK;

  bram_rd_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .START_ADDR (START_ADDR),
    .LEN        (LEN),
    .STALL      (STALL),
    .EN_B       (EN_B),
    .ADDR_B     (ADDR_B),
    .SM_EN      (SM_EN),
    .Sel        (Sel),
    .OUT_VALID  (OUT_VALID),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  // Cycles where the read-latency timing rule is broken: data one cycle and
  // the output valid two cycles after each read enable.
  function automatic int pipe_mis();
    int m = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (sm_h[k] != ((k >= 1) ? en_h[k-1] : 1'b0)) m++;
      if (vld_h[k] != ((k >= 2) ? en_h[k-2] : 1'b0)) m++;
    end
    return m;
  endfunction

  // Drive one request and record what the DUT does until shortly after DONE.
  task automatic run_xfer(input logic [ADDR_W+1:0] sa, input int len,
                          input int stall_after, input int stall_len,
                          input bit rnd_stall, input int restart_at);
    int stall_left = 0;
    bit triggered = 0;
    int issues = 0;
    int tail = -1;
    addr_obs.delete();
    for (int i = 0; i < MAXC; i++) begin
      en_h[i] = 0; sm_h[i] = 0; vld_h[i] = 0;
    end
    ncyc = 0; done_cnt = 0; done_cyc = -1; vld_cnt = 0; first_vld = -1;
    last_vld = -1; first_en = -1; last_en = -1; sel_bad = 0;
    busy_after = 0; busy_cnt = 0;
    @(posedge CLK); #1;
    START = 1'b1; START_ADDR = sa; LEN = LEN_W'(len);
    STALL = rnd_stall ? ($urandom_range(0, 2) == 0) : 1'b0;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int k = 0; k < MAXC; k++) begin
      @(negedge CLK);
      en_h[k] = EN_B; sm_h[k] = SM_EN; vld_h[k] = OUT_VALID; ncyc = k + 1;
      if (EN_B) begin
        addr_obs.push_back(int'(ADDR_B));
        issues++;
        if (first_en < 0) first_en = k;
        last_en = k;
      end
      if (OUT_VALID) begin
        vld_cnt++;
        if (first_vld < 0) first_vld = k;
        last_vld = k;
      end
      if (BUSY) busy_cnt++;
      if (tail >= 0 && BUSY) busy_after++;
      if (DONE) begin
        done_cnt++;
        done_cyc = k;
        if (tail < 0) tail = k;
      end
      if (BUSY && Sel !== sa[1:0]) sel_bad++;
      if (!BUSY && Sel !== 2'd0) sel_bad++;
      if (!triggered && stall_len > 0 && issues == stall_after) begin
        triggered = 1; stall_left = stall_len;
      end
      if (tail >= 0 && k >= tail + 3) break;
      @(posedge CLK); #1;
      START = (k == restart_at);
      if (k == restart_at) begin
        START_ADDR = sa ^ 12'h0F5;
        LEN = LEN_W'(len + 5);
      end
      if (rnd_stall) STALL = ($urandom_range(0, 2) == 0);
      else if (stall_left > 0) begin STALL = 1'b1; stall_left--; end
      else STALL = 1'b0;
    end
    timeout = (tail < 0);
    START = 1'b0; STALL = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #3;
    checks++;
    if ({EN_B, ADDR_B, SM_EN, Sel, OUT_VALID, BUSY, DONE} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {EN_B, ADDR_B, SM_EN, Sel, OUT_VALID, BUSY, DONE});
    end
    @(negedge CLK); RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({EN_B, SM_EN, OUT_VALID, BUSY, DONE} !== '0) begin
      errors++;
      $display("FAIL idle_after_release got %b exp 0", {EN_B, SM_EN, OUT_VALID, BUSY, DONE});
    end
  endtask

  task automatic test_basic();
    int exp_a[4] = '{4, 5, 6, 7};
    run_xfer(12'h010, 4, 0, 0, 0, -1);
    checks++;
    if (addr_obs.size() != 4) begin errors++; $display("FAIL basic_issues got %0d exp 4", addr_obs.size()); end
    for (int i = 0; i < 4 && i < addr_obs.size(); i++) begin
      checks++;
      if (addr_obs[i] != exp_a[i]) begin errors++; $display("FAIL basic_addr%0d got %0d exp %0d", i, addr_obs[i], exp_a[i]); end
    end
    checks++;
    if (first_en != 0 || last_en != 3) begin errors++; $display("FAIL basic_en_window got %0d..%0d exp 0..3", first_en, last_en); end
    checks++;
    if (vld_cnt != 4 || first_vld != 2) begin errors++; $display("FAIL basic_valid got cnt %0d first %0d exp 4 at 2", vld_cnt, first_vld); end
    checks++;
    if (pipe_mis() != 0) begin errors++; $display("FAIL basic_latency got %0d bad cycles exp 0", pipe_mis()); end
    checks++;
    if (done_cnt != 1 || done_cyc != 5) begin errors++; $display("FAIL basic_done got cnt %0d cyc %0d exp 1 at 5", done_cnt, done_cyc); end
    checks++;
    if (sel_bad != 0 || busy_after != 0 || timeout) begin errors++; $display("FAIL basic_sel_busy got sel_bad %0d busy_after %0d to %0d exp 0 0 0", sel_bad, busy_after, timeout); end
  endtask

  task automatic test_offset();
    run_xfer(12'h013, 2, 0, 0, 0, -1);
    checks++;
    if (addr_obs.size() != 2 || addr_obs[0] != 4 || addr_obs[1] != 5) begin
      errors++; $display("FAIL offset_addr got n=%0d exp 4,5", addr_obs.size());
    end
    checks++;
    if (sel_bad != 0) begin errors++; $display("FAIL offset_sel got %0d bad cycles exp 0 (Sel 3)", sel_bad); end
    checks++;
    if (vld_cnt != 2 || done_cnt != 1 || done_cyc != last_vld || last_vld != 3) begin
      errors++; $display("FAIL offset_done got vld %0d done %0d at %0d exp 2 1 at 3", vld_cnt, done_cnt, done_cyc);
    end
  endtask

  task automatic test_wrap();
    int exp_a[4] = '{1022, 1023, 0, 1};
    run_xfer({10'd1022, 2'b00}, 4, 0, 0, 0, -1);
    checks++;
    if (addr_obs.size() != 4) begin errors++; $display("FAIL wrap_issues got %0d exp 4", addr_obs.size()); end
    for (int i = 0; i < 4 && i < addr_obs.size(); i++) begin
      checks++;
      if (addr_obs[i] != exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d got %0d exp %0d", i, addr_obs[i], exp_a[i]); end
    end
    checks++;
    if (vld_cnt != 4 || done_cnt != 1) begin errors++; $display("FAIL wrap_done got vld %0d done %0d exp 4 1", vld_cnt, done_cnt); end
  endtask

  task automatic test_stall();
    int base = $urandom_range(0, AMOD - 1);
    bit exp_en[11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    int bad = 0;
    run_xfer({ADDR_W'(base), 2'b10}, 8, 2, 3, 0, -1);
    for (int k = 0; k < 11; k++) if (en_h[k] != exp_en[k]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_gap got %0d bad enable cycles exp 0", bad); end
    checks++;
    if (addr_obs.size() != 8) begin errors++; $display("FAIL stall_issues got %0d exp 8", addr_obs.size()); end
    for (int i = 0; i < 8 && i < addr_obs.size(); i++) begin
      checks++;
      if (addr_obs[i] != (base + i) % AMOD) begin errors++; $display("FAIL stall_addr%0d got %0d exp %0d", i, addr_obs[i], (base + i) % AMOD); end
    end
    checks++;
    if (vld_cnt != 8 || done_cnt != 1 || done_cyc != 12 || pipe_mis() != 0) begin
      errors++; $display("FAIL stall_done got vld %0d done %0d at %0d pipe %0d exp 8 1 at 12 0", vld_cnt, done_cnt, done_cyc, pipe_mis());
    end
  endtask

  task automatic test_zero_and_ignore();
    int base = $urandom_range(0, AMOD - 1);
    run_xfer(12'h2A1, 0, 0, 0, 0, -1);
    checks++;
    if (addr_obs.size() != 0 || busy_cnt != 0) begin errors++; $display("FAIL zero_no_reads got issues %0d busy %0d exp 0 0", addr_obs.size(), busy_cnt); end
    checks++;
    if (done_cnt != 1 || done_cyc != 0 || vld_cnt != 0) begin errors++; $display("FAIL zero_done got %0d at %0d vld %0d exp 1 at 0 vld 0", done_cnt, done_cyc, vld_cnt); end
    run_xfer({ADDR_W'(base), 2'b01}, 6, 0, 0, 0, 1);
    checks++;
    if (addr_obs.size() != 6 || vld_cnt != 6 || done_cnt != 1) begin
      errors++; $display("FAIL ignore_count got issues %0d vld %0d done %0d exp 6 6 1", addr_obs.size(), vld_cnt, done_cnt);
    end
    checks++;
    if (addr_obs.size() == 6 && addr_obs[5] != (base + 5) % AMOD) begin
      errors++; $display("FAIL ignore_addr got %0d exp %0d", addr_obs[5], (base + 5) % AMOD);
    end
    checks++;
    if (sel_bad != 0) begin errors++; $display("FAIL ignore_sel got %0d bad cycles exp 0", sel_bad); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int bad = 0;
    int base = $urandom_range(0, AMOD - 1);
    @(posedge CLK); #1;
    START = 1'b1; START_ADDR = {ADDR_W'(base), 2'b11}; LEN = LEN_W'(6);
    @(posedge CLK); #1;
    START = 1'b0;
    for (int k = 0; k < 40 && n < 3; k++) begin
      @(negedge CLK);
      if (EN_B) n++;
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL rstmid_issues got %0d exp 3", n); end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({EN_B, ADDR_B, SM_EN, Sel, OUT_VALID, BUSY, DONE} !== '0) begin
      errors++; $display("FAIL rstmid_outputs got %h exp 0", {EN_B, ADDR_B, SM_EN, Sel, OUT_VALID, BUSY, DONE});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if ({DONE, OUT_VALID, SM_EN, EN_B, BUSY} !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles exp 0", bad); end
    RST_N = 1'b1;
    run_xfer(12'h155, 1, 0, 0, 0, -1);
    checks++;
    if (addr_obs.size() != 1 || vld_cnt != 1 || done_cnt != 1 || done_cyc != 2) begin
      errors++; $display("FAIL rstmid_after got issues %0d vld %0d done %0d at %0d exp 1 1 1 at 2", addr_obs.size(), vld_cnt, done_cnt, done_cyc);
    end
    checks++;
    if (addr_obs.size() == 1 && addr_obs[0] != 12'h155 >> 2) begin
      errors++; $display("FAIL rstmid_addr got %0d exp %0d", addr_obs[0], 12'h155 >> 2);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int base = $urandom_range(0, AMOD - 1);
      int len = $urandom_range(1, 24);
      int abad = 0;
      logic [1:0] off = 2'($urandom_range(0, 3));
      run_xfer({ADDR_W'(base), off}, len, 0, 0, 1, -1);
      for (int i = 0; i < addr_obs.size(); i++) if (addr_obs[i] != (base + i) % AMOD) abad++;
      checks++;
      if (addr_obs.size() != len || abad != 0) begin
        errors++; $display("FAIL rand%0d_addr got issues %0d bad %0d exp %0d 0", t, addr_obs.size(), abad, len);
      end
      checks++;
      if (vld_cnt != len || pipe_mis() != 0) begin
        errors++; $display("FAIL rand%0d_valid got %0d pipe %0d exp %0d 0", t, vld_cnt, pipe_mis(), len);
      end
      checks++;
      if (timeout || done_cnt != 1 || done_cyc != last_vld || done_cyc != last_en + 2) begin
        errors++; $display("FAIL rand%0d_done got %0d at %0d exp 1 at %0d", t, done_cnt, done_cyc, last_en + 2);
      end
      checks++;
      if (sel_bad != 0 || busy_after != 0) begin
        errors++; $display("FAIL rand%0d_sel_busy got %0d %0d exp 0 0", t, sel_bad, busy_after);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_offset();
    test_wrap();
    test_stall();
    test_zero_and_ignore();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
